// File: rtl/kmul_pkg.sv
// Shared definitions for the iterative Karatsuba multiplier.
//   kmul_half(w)  : half operand width used by the shared core
//   kmul_lat(l)   : accept-to-out_valid latency for a core latency of l cycles
//   kmul_state_t  : sequencing states of the top-level FSM
package kmul_pkg;

  typedef enum logic [2:0] {IDLE, P_LO, P_HI, P_MID, COMBINE, HOLD} kmul_state_t;

  function automatic int kmul_half(input int w);
    return w / 2;
  endfunction

  function automatic int kmul_lat(input int mul_lat);
    return 3 * mul_lat + 1;
  endfunction

endpackage

// File: rtl/kmul_core_pipe.sv
// (H+1)x(H+1) unsigned multiplier followed by MUL_LAT register stages.
//   clk, reset (async, active low, clears every stage)
//   a, b : H+1-bit operands (the extra bit carries the xl+xh / yl+yh sum)
//   p    : 2H+2-bit product, valid MUL_LAT cycles after a/b were presented
module kmul_core_pipe #(
  parameter int H       = 23,
  parameter int MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [H:0]     a,
  input  logic [H:0]     b,
  output logic [2*H+1:0] p
);

  logic [2*H+1:0]                 prod;
  logic [MUL_LAT-1:0][2*H+1:0]    stage;

  assign prod = {{(H+1){1'b0}}, a} * {{(H+1){1'b0}}, b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage[0] <= prod;
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/karatsuba_mul_iter.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one-level Karatsuba, with one
// half-width core reused over three passes (lo, hi, mid).
//   clk, reset (async, active low)
//   in_valid/in_ready/x/y       : operand handshake
//   out_valid/out_ready/out     : product handshake, out held until accepted
//   busy                        : high whenever the FSM is not IDLE
module karatsuba_mul_iter
  import kmul_pkg::*;
#(
  parameter int WIDTH   = 46,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int H  = kmul_half(WIDTH);
  localparam int P  = 2*H + 2;
  localparam int OW = 2*WIDTH;
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  generate
    if (WIDTH % 2 != 0) begin : g_width_odd
      $error("karatsuba_mul_iter: WIDTH must be even");
    end
    if (MUL_LAT < 1) begin : g_lat_bad
      $error("karatsuba_mul_iter: MUL_LAT must be >= 1");
    end
  endgenerate

  kmul_state_t     state;
  logic [WIDTH-1:0] xr, yr;
  logic [P-1:0]    m00, m11, mid, core_p;
  logic [H:0]      core_a, core_b;
  logic [OW-1:0]   mid_w, sum;
  logic [CW-1:0]   cnt;
  logic            pass_done, accept;

  assign pass_done = (cnt == CNT_LAST);
  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);

  // Each pass holds its operands for MUL_LAT cycles. The core is pipelined,
  // so a pass's product shows up on core_p during the following pass:
  // lo product during P_HI, hi product during P_MID, mid product in COMBINE.
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state)
      P_LO: begin
        core_a = {1'b0, xr[H-1:0]};
        core_b = {1'b0, yr[H-1:0]};
      end
      P_HI: begin
        core_a = {1'b0, xr[WIDTH-1:H]};
        core_b = {1'b0, yr[WIDTH-1:H]};
      end
      P_MID: begin
        core_a = {1'b0, xr[H-1:0]} + {1'b0, xr[WIDTH-1:H]};
        core_b = {1'b0, yr[H-1:0]} + {1'b0, yr[WIDTH-1:H]};
      end
      default: ;
    endcase
  end

  kmul_core_pipe #(.H(H), .MUL_LAT(MUL_LAT)) u_core (
    .clk   (clk),
    .reset (reset),
    .a     (core_a),
    .b     (core_b),
    .p     (core_p)
  );

  // mid = (xl+xh)(yl+yh) - xh*yh - xl*yl = xl*yh + xh*yl, never negative.
  // m10 is consumed straight off the core output during COMBINE.
  always_comb begin
    mid   = core_p - m11 - m00;
    mid_w = '0;
    mid_w[P-1:0] = mid;
    sum   = {m11[2*H-1:0], m00[2*H-1:0]} + (mid_w << H);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      m00       <= '0;
      m11       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          xr    <= x;
          yr    <= y;
          cnt   <= '0;
          state <= P_LO;
        end
        P_LO: if (pass_done) begin
          cnt   <= '0;
          state <= P_HI;
        end else cnt <= cnt + CW'(1);
        P_HI: begin
          m00 <= core_p;
          if (pass_done) begin
            cnt   <= '0;
            state <= P_MID;
          end else cnt <= cnt + CW'(1);
        end
        P_MID: begin
          m11 <= core_p;
          if (pass_done) begin
            cnt   <= '0;
            state <= COMBINE;
          end else cnt <= cnt + CW'(1);
        end
        COMBINE: begin
          out       <= sum;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            cnt   <= '0;
            state <= P_LO;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mul_iter.sv
// Self-checking bench: a 46-bit / latency-1 instance and an 8-bit / latency-3
// instance, compared against plain-integer products.
module tb_karatsuba_mul_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [45:0] a_x, a_y;
  logic [91:0] a_out;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_x, b_y;
  logic [15:0] b_out;

  int checks = 0;
  int errors = 0;

  karatsuba_mul_iter #(.WIDTH(46), .MUL_LAT(1)) dut_a (
    .clk(clk), .reset(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .busy(a_busy));

  karatsuba_mul_iter #(.WIDTH(8), .MUL_LAT(3)) dut_b (
    .clk(clk), .reset(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .busy(b_busy));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 46-bit instance with out_ready held high.
  task automatic run_a(input logic [45:0] xv, input logic [45:0] yv, input string tag);
    logic [91:0] expv;
    int n;
    expv = {46'd0, xv} * {46'd0, yv};
    @(negedge clk);
    a_x = xv; a_y = yv; a_in_valid = 1'b1; a_out_ready = 1'b1;
    chk({tag, " in_ready"}, a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, 4);
    chk({tag, " product"}, a_out, expv);
    chk({tag, " busy"}, a_busy, 1);
    @(negedge clk);
    chk({tag, " valid width"}, a_out_valid, 0);
    chk({tag, " out held"}, a_out, expv);
  endtask

  task automatic run_b(input logic [7:0] xv, input logic [7:0] yv, input string tag);
    logic [15:0] expv;
    int n;
    expv = {8'd0, xv} * {8'd0, yv};
    @(negedge clk);
    b_x = xv; b_y = yv; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk({tag, " latency"}, n, 10);
    chk({tag, " product"}, b_out, expv);
    @(negedge clk);
    chk({tag, " valid drop"}, b_out_valid, 0);
  endtask

  initial begin
    logic [45:0] xs, ys, x2, y2;
    logic [91:0] e1, e2;
    logic [7:0]  corner [5];
    int n;

    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_x = '0; a_y = '0;
    b_in_valid = 0; b_out_ready = 0; b_x = '0; b_y = '0;
    #1;
    chk("rst a out_valid", a_out_valid, 0);
    chk("rst a out", a_out, 0);
    chk("rst a busy", a_busy, 0);
    chk("rst b out", b_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst a in_ready", a_in_ready, 1);
    chk("rst b in_ready", b_in_ready, 1);
    chk("rst b out_valid", b_out_valid, 0);

    // Directed corners on the 46-bit instance
    run_a(46'd1, 46'd1, "one");
    chk("one exact", a_out, 1);
    run_a({46{1'b1}}, {46{1'b1}}, "max");
    chk("max exact", a_out, (128'd1 << 92) - (128'd1 << 47) + 128'd1);
    run_a(46'd1 << 23, 46'd1 << 23, "pow23");
    chk("pow23 exact", a_out, 128'd1 << 46);
    run_a((46'd1 << 23) - 46'd1, {46{1'b1}}, "split");
    run_a(46'd0, {46{1'b1}}, "zero");
    run_a({23'd0, {23{1'b1}}}, {{23{1'b1}}, 23'd0}, "lohi");

    for (int i = 0; i < 20; i++) begin
      xs = {$urandom(), $urandom()};
      ys = {$urandom(), $urandom()};
      run_a(xs, ys, "rand46");
    end

    // in_valid during the passes is ignored
    xs = {$urandom(), $urandom()};
    ys = {$urandom(), $urandom()};
    e1 = {46'd0, xs} * {46'd0, ys};
    @(negedge clk);
    a_x = xs; a_y = ys; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_x = ~xs; a_y = ys + 46'd7;
    chk("ignore in_ready p_lo", a_in_ready, 0);
    @(negedge clk);
    chk("ignore in_ready p_hi", a_in_ready, 0);
    a_in_valid = 1'b0;
    n = 1;
    while (a_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ignore latency", n, 4);
    chk("ignore product", a_out, e1);
    @(negedge clk);

    // Back-pressure in HOLD, then back-to-back accept on the releasing edge
    xs = {$urandom(), $urandom()};
    ys = {$urandom(), $urandom()};
    x2 = {$urandom(), $urandom()};
    y2 = {$urandom(), $urandom()};
    e1 = {46'd0, xs} * {46'd0, ys};
    e2 = {46'd0, x2} * {46'd0, y2};
    @(negedge clk);
    a_x = xs; a_y = ys; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("bp latency", n, 4);
    repeat (10) begin
      @(negedge clk);
      chk("bp out_valid", a_out_valid, 1);
      chk("bp out", a_out, e1);
      chk("bp in_ready", a_in_ready, 0);
    end
    a_x = x2; a_y = y2; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    chk("bp in_ready follows out_ready", a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("b2b out_valid drop", a_out_valid, 0);
    chk("b2b busy", a_busy, 1);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("b2b latency", n, 4);
    chk("b2b product", a_out, e2);
    @(negedge clk);

    // Reset pulse while in P_HI
    @(negedge clk);
    a_x = 46'h3ff_ffff_1234; a_y = 46'h1234_5678; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", a_out_valid, 0);
    chk("midrst out", a_out, 0);
    chk("midrst busy", a_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", a_in_ready, 1);
    run_a(46'h2_0000_0003, 46'h15, "after rst");

    // 8-bit / latency-3 instance: operand corners plus random pairs
    corner[0] = 8'd0; corner[1] = 8'd1; corner[2] = 8'd15;
    corner[3] = 8'd16; corner[4] = 8'd255;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        run_b(corner[i], corner[j], "b corner");
    for (int i = 0; i < 2000; i++)
      run_b(8'($urandom()), 8'($urandom()), "b rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
